// File: rtl/rf_arb_pkg.sv
// Shared types, default widths and helpers for the register-file write arbiter.
package rf_arb_pkg;

  localparam int RF_NUM_REQ     = 3;
  localparam int RF_ADDR_W      = 5;
  localparam int RF_DATA_W      = 32;
  localparam int RF_MAX_ADDR_W  = 8;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  // Callers zero-extend their address to RF_MAX_ADDR_W bits.
  function automatic logic rd_is_x0(input logic [RF_MAX_ADDR_W-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/rf_arb_age_matrix.sv
// N x N age matrix: older_q[i][j]=1 means entry i was accepted before entry j.
// Grants the valid entry that is older than every other valid entry.
module rf_arb_age_matrix
  import rf_arb_pkg::*;
#(
  parameter int N = RF_NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] accept,
  input  logic [N-1:0] free,
  output logic [N-1:0] grant
);

  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];
  logic [N-1:0] survive;

  assign survive = valid & ~free;

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = valid[i] && (&(older_q[i] | ~valid | (N'(1) << i)));
    end
  end

  // A slot freed and re-accepted on the same edge takes the accept path.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i == j)                       older_d[i][j] = 1'b0;
        else if (accept[i] && accept[j])  older_d[i][j] = (i < j);
        else if (accept[i])               older_d[i][j] = 1'b0;
        else if (accept[j])               older_d[i][j] = survive[i];
        else if (free[i] || free[j])      older_d[i][j] = 1'b0;
        else                              older_d[i][j] = older_q[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) older_q[i] <= '0;
      else     older_q[i] <= older_d[i];
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares one register-file write port among lockstep writeback slots, each with a
// one-entry hold register drained oldest-first; stalls all slots when a write cannot be held.
module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_data,
  output logic                      stall_out,
  output logic [NUM_REQ-1:0]        pend_valid,
  output logic [NUM_REQ*ADDR_W-1:0] pend_rd,
  output logic [NUM_REQ*DATA_W-1:0] pend_data
);

  logic [NUM_REQ-1:0] hold_valid;
  logic [ADDR_W-1:0]  hold_rd   [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [NUM_REQ-1:0] eff;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [ADDR_W-1:0]  grant_rd;
  logic [DATA_W-1:0]  grant_data;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eff[i] = req_wr_en[i] &&
               !rd_is_x0(RF_MAX_ADDR_W'(req_rd[i*ADDR_W +: ADDR_W]));
    end
  end

  // A hold being granted this cycle is free for its slot's new write.
  assign stall_out = |(eff & hold_valid & ~grant);
  // All-or-nothing accept: lockstep pipelines re-present every slot after a stall.
  assign accept    = stall_out ? '0 : eff;

  rf_arb_age_matrix #(.N(NUM_REQ)) u_age (
    .clk    (clk),
    .rst    (rst),
    .valid  (hold_valid),
    .accept (accept),
    .free   (grant),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        hold_valid[i] <= 1'b0;
      end else if (accept[i]) begin
        hold_valid[i] <= 1'b1;
        hold_rd[i]    <= req_rd[i*ADDR_W +: ADDR_W];
        hold_data[i]  <= req_data[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        hold_valid[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    grant_rd   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_rd   = grant_rd   | hold_rd[i];
        grant_data = grant_data | hold_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en <= 1'b0;
      rf_rd    <= '0;
      rf_data  <= '0;
    end else begin
      rf_wr_en <= |grant;
      rf_rd    <= grant_rd;
      rf_data  <= grant_data;
    end
  end

  assign pend_valid = hold_valid;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_rd[i*ADDR_W +: ADDR_W]   = hold_rd[i];
      pend_data[i*DATA_W +: DATA_W] = hold_data[i];
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus random lockstep traffic, checked
// against a FIFO-of-accepted-writes model of the arbiter.
module tb_rf_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_wr_en;
  logic [N*AW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_data;
  logic            stall_out;
  logic [N-1:0]    pend_valid;
  logic [N*AW-1:0] pend_rd;
  logic [N*DW-1:0] pend_data;

  rf_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_wr_en  (req_wr_en),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .rf_wr_en   (rf_wr_en),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .stall_out  (stall_out),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd),
    .pend_data  (pend_data)
  );

  always #5 clk = ~clk;

  // Model: every accepted write waits in one FIFO in acceptance order, remembering its slot.
  typedef struct {
    int            slot;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          exp_q[$];
  logic          exp_en;
  logic [AW-1:0] exp_rd;
  logic [DW-1:0] exp_data;
  logic          exp_stall;
  int            n_cmp;
  int            n_fail;
  int            stall_cycles;
  int            wr_count;
  logic [DW-1:0] rf_obs [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic en, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    req_wr_en[i]          = en;
    req_rd[i*AW +: AW]    = rd;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic drive_all(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    drive(0, 1'b1, a, 32'hC000_0000 | DW'(a));
    drive(1, 1'b1, b, 32'hC000_0000 | DW'(b));
    drive(2, 1'b1, c, 32'hC000_0000 | DW'(c));
  endtask

  task automatic idle();
    req_wr_en = '0;
    req_rd    = '0;
    req_data  = '0;
  endtask

  // Called just after a negedge with inputs applied: check, advance model, cross one edge.
  task automatic step();
    logic [N-1:0] eff;
    logic [N-1:0] pv;
    ent_t         e;
    #1;
    for (int i = 0; i < N; i++) eff[i] = req_wr_en[i] && (req_rd[i*AW +: AW] != '0);
    exp_stall = 1'b0;
    for (int k = 1; k < exp_q.size(); k++) if (eff[exp_q[k].slot]) exp_stall = 1'b1;
    chk("stall_out", 64'(stall_out), 64'(exp_stall));
    chk("rf_wr_en", 64'(rf_wr_en), 64'(exp_en));
    if (exp_en) begin
      chk("rf_rd", 64'(rf_rd), 64'(exp_rd));
      chk("rf_data", 64'(rf_data), 64'(exp_data));
    end
    if (rf_wr_en === 1'b1) begin
      rf_obs[rf_rd] = rf_data;
      wr_count++;
    end
    if (stall_out === 1'b1) stall_cycles++;
    pv = '0;
    foreach (exp_q[k]) begin
      pv[exp_q[k].slot] = 1'b1;
      chk("pend_rd", 64'(pend_rd[exp_q[k].slot*AW +: AW]), 64'(exp_q[k].rd));
      chk("pend_data", 64'(pend_data[exp_q[k].slot*DW +: DW]), 64'(exp_q[k].data));
    end
    chk("pend_valid", 64'(pend_valid), 64'(pv));
    if (rst) begin
      exp_q.delete();
      exp_en   = 1'b0;
      exp_rd   = '0;
      exp_data = '0;
    end else begin
      exp_en = 1'b0;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        exp_en   = 1'b1;
        exp_rd   = e.rd;
        exp_data = e.data;
      end
      if (!exp_stall) begin
        for (int i = 0; i < N; i++) begin
          if (eff[i]) begin
            e.slot = i;
            e.rd   = req_rd[i*AW +: AW];
            e.data = req_data[i*DW +: DW];
            exp_q.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (N + 2) step();
  endtask

  initial begin
    int s0;
    int w0;
    n_cmp = 0; n_fail = 0; stall_cycles = 0; wr_count = 0;
    exp_en = 1'b0; exp_rd = '0; exp_data = '0; exp_stall = 1'b0;
    for (int r = 0; r < 32; r++) rf_obs[r] = '0;
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    chk("reset_rf_wr_en", 64'(rf_wr_en), 64'(0));
    chk("reset_rf_rd", 64'(rf_rd), 64'(0));
    chk("reset_rf_data", 64'(rf_data), 64'(0));
    chk("reset_pend_valid", 64'(pend_valid), 64'(0));
    chk("reset_stall", 64'(stall_out), 64'(0));
    @(negedge clk);

    // Single write: visible two edges after it is presented
    drive(0, 1'b1, 5'd5, 32'hAAAA_0001);
    step();
    idle();
    step();
    chk("t1_rf_wr_en", 64'(rf_wr_en), 64'(1));
    chk("t1_rf_rd", 64'(rf_rd), 64'(5));
    chk("t1_rf_data", 64'(rf_data), 64'hAAAA_0001);
    drain();
    chk("t1_no_stall", 64'(stall_cycles), 64'(0));

    // All slots at once into empty holds
    drive_all(5'd1, 5'd2, 5'd3);
    step();
    idle();
    drain();
    chk("t2_no_stall", 64'(stall_cycles), 64'(0));

    // Back-to-back all-slot writes; second group held until accepted
    s0 = stall_cycles;
    w0 = wr_count;
    drive_all(5'd1, 5'd2, 5'd3);
    step();
    drive_all(5'd4, 5'd5, 5'd6);
    for (int k = 0; k < 8; k++) begin
      step();
      if (!exp_stall) break;
    end
    drain();
    chk("t3_stall_cycles", 64'(stall_cycles - s0), 64'(2));
    chk("t3_write_count", 64'(wr_count - w0), 64'(6));

    // Same rd from two slots in one cycle: higher slot wins
    drive(0, 1'b1, 5'd7, 32'h11);
    drive(1, 1'b0, 5'd0, 32'h0);
    drive(2, 1'b1, 5'd7, 32'h22);
    step();
    drain();
    chk("t4_final_rd7", 64'(rf_obs[7]), 64'h22);

    // Writes to x0 while holds are full never stall
    drive_all(5'd8, 5'd9, 5'd10);
    step();
    drive(0, 1'b0, 5'd0, 32'h0);
    drive(1, 1'b1, 5'd0, 32'hDEAD);
    drive(2, 1'b1, 5'd0, 32'hBEEF);
    step();
    chk("t5_pend_after_x0", 64'(pend_valid), 64'(3'b110));
    drain();

    // Reset with three pending writes discards them
    drive_all(5'd11, 5'd12, 5'd13);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_pend_valid", 64'(pend_valid), 64'(0));
    chk("t6_rf_wr_en", 64'(rf_wr_en), 64'(0));
    chk("t6_stall", 64'(stall_out), 64'(0));
    @(negedge clk);
    drain();
    chk("t6_rd11_untouched", 64'(rf_obs[11]), 64'(0));
    chk("t6_rd13_untouched", 64'(rf_obs[13]), 64'(0));

    // Random lockstep traffic; inputs are re-presented while the model predicts a stall
    exp_stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!exp_stall) begin
        for (int i = 0; i < N; i++) begin
          drive(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom_range(1, 31)),
                $urandom);
        end
      end
      step();
    end
    drain();
    chk("final_pend_empty", 64'(pend_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
